// File: rtl/seg_readback_if.sv
// ---------------------------------------------------------------------------
// seg_readback_if
//   Bundle of signals between a two-digit seven-segment display bus and the
//   seg_readback monitor.
//
//   seg_ten / seg_one : active-low segment patterns {a,b,c,d,e,f,g,dp}
//   value             : last accepted decoded value, 0..99
//   value_valid       : a legal value has been accepted since reset
//   step_up/step_down : one-cycle pulses for +1 / -1 steps
//   jump              : one-cycle pulse for any other legal change
//   illegal           : one-cycle pulse for an undecodable accepted pair
//   dir               : 0 = counting up, 1 = counting down
//   turn_count        : saturating count of direction reversals
//
//   master : the side driving the display bus (observes the results)
//   slave  : the monitor
// ---------------------------------------------------------------------------
interface seg_readback_if #(
    parameter int TURN_W = 8
);
    logic [7:0]        seg_ten;
    logic [7:0]        seg_one;
    logic [6:0]        value;
    logic              value_valid;
    logic              step_up;
    logic              step_down;
    logic              jump;
    logic              illegal;
    logic              dir;
    logic [TURN_W-1:0] turn_count;

    modport master (
        output seg_ten, seg_one,
        input  value, value_valid, step_up, step_down, jump, illegal,
               dir, turn_count
    );

    modport slave (
        input  seg_ten, seg_one,
        output value, value_valid, step_up, step_down, jump, illegal,
               dir, turn_count
    );
endinterface

// File: rtl/seg_readback.sv
// ---------------------------------------------------------------------------
// seg_readback
//   Receive-side monitor for the two-digit ping-pong counter display.
//   Registers the tens/ones segment patterns, waits until the pair has been
//   stable for STABLE_CYCLES clocks, decodes it back to 0..99 and classifies
//   each accepted change as a +1 step, a -1 step, a jump or an illegal pair.
//   Direction reversals are counted (saturating).
//
//   Ports:
//     clk  - system clock
//     rst  - synchronous, active-low reset
//     bus  - seg_readback_if.slave: segment inputs and all result outputs
//
//   Parameters:
//     STABLE_CYCLES - clocks a pattern pair must hold before acceptance
//                     (2..255)
//     TURN_W        - width of the turnaround counter
// ---------------------------------------------------------------------------
module seg_readback #(
    parameter int STABLE_CYCLES = 4,
    parameter int TURN_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_readback_if.slave        bus
);

    typedef enum logic {
        S_EMPTY,
        S_TRACK
    } state_t;

    localparam logic [7:0]        CNT_MAX   = 8'(STABLE_CYCLES);
    localparam logic [7:0]        CNT_FIRE  = 8'(STABLE_CYCLES - 1);
    localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);
    localparam logic [TURN_W-1:0] TURN_SAT  = '1;

    // Returns {legal, digit}. A blank tens digit reads as a leading zero.
    function automatic logic [4:0] decode_digit(input logic [7:0] pat,
                                                input logic       blank_is_zero);
        logic [4:0] r;
        r = 5'b0_0000;
        case (pat)
            8'h03: r = {1'b1, 4'd0};
            8'h9F: r = {1'b1, 4'd1};
            8'h25: r = {1'b1, 4'd2};
            8'h0D: r = {1'b1, 4'd3};
            8'h99: r = {1'b1, 4'd4};
            8'h49: r = {1'b1, 4'd5};
            8'h41: r = {1'b1, 4'd6};
            8'h1F: r = {1'b1, 4'd7};
            8'h01: r = {1'b1, 4'd8};
            8'h09: r = {1'b1, 4'd9};
            8'hFF: r = blank_is_zero ? {1'b1, 4'd0} : 5'b0_0000;
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Input stage and stability tracking
    logic [15:0]       smp_q;
    logic [15:0]       smp_d_q;
    logic [7:0]        cnt_q;

    // Tracked state and registered outputs
    state_t            state_q, state_d;
    logic [6:0]        value_q, value_d;
    logic              valid_q, valid_d;
    logic              dir_q, dir_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              up_q, up_d;
    logic              down_q, down_d;
    logic              jump_q, jump_d;
    logic              ill_q, ill_d;

    logic              accept;
    logic [4:0]        ten_dec;
    logic [4:0]        one_dec;
    logic              legal;
    logic [6:0]        new_val;
    logic signed [7:0] diff;
    logic [TURN_W-1:0] turn_inc;

    // Fires once per stable run: the counter passes CNT_FIRE exactly once
    // before it either saturates or is cleared by a change.
    assign accept  = (cnt_q == CNT_FIRE);

    // smp_d_q is the pattern that has actually been held for the run.
    assign ten_dec = decode_digit(smp_d_q[15:8], 1'b1);
    assign one_dec = decode_digit(smp_d_q[7:0],  1'b0);
    assign legal   = ten_dec[4] & one_dec[4];
    assign new_val = ({3'b000, ten_dec[3:0]} * 7'd10) + {3'b000, one_dec[3:0]};
    assign diff    = signed'({1'b0, new_val}) - signed'({1'b0, value_q});

    assign turn_inc = (turn_q == TURN_SAT) ? turn_q : turn_q + TURN_ONE;

    // NOTE: every clocked assignment is non-blocking so all registers see the
    // same pre-edge values; blocking here would make ordering matter.
    // NOTE: the sample registers reset to the blank pattern so that reset
    // release looks like a fresh change and never accepts stale data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            smp_q   <= 16'hFFFF;
            smp_d_q <= 16'hFFFF;
            cnt_q   <= 8'd0;
            state_q <= S_EMPTY;
            value_q <= 7'd0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            turn_q  <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            jump_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            smp_q   <= {bus.seg_ten, bus.seg_one};
            smp_d_q <= smp_q;
            if (smp_q != smp_d_q)
                cnt_q <= 8'd0;
            else if (cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 8'd1;
            state_q <= state_d;
            value_q <= value_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            turn_q  <= turn_d;
            up_q    <= up_d;
            down_q  <= down_d;
            jump_q  <= jump_d;
            ill_q   <= ill_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        valid_d = valid_q;
        dir_d   = dir_q;
        turn_d  = turn_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        jump_d  = 1'b0;
        ill_d   = 1'b0;

        if (accept) begin
            if (!legal) begin
                ill_d = 1'b1;
            end else begin
                case (state_q)
                    S_EMPTY: begin
                        value_d = new_val;
                        valid_d = 1'b1;
                        state_d = S_TRACK;
                    end
                    S_TRACK: begin
                        if (diff == 8'sd0) begin
                            // re-accept of the held value: nothing to report
                        end else if (diff == 8'sd1) begin
                            up_d    = 1'b1;
                            value_d = new_val;
                            if (dir_q) begin
                                dir_d  = 1'b0;
                                turn_d = turn_inc;
                            end
                        end else if (diff == -8'sd1) begin
                            down_d  = 1'b1;
                            value_d = new_val;
                            if (!dir_q) begin
                                dir_d  = 1'b1;
                                turn_d = turn_inc;
                            end
                        end else begin
                            jump_d  = 1'b1;
                            value_d = new_val;
                        end
                    end
                    default: state_d = S_EMPTY;
                endcase
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;
    assign bus.step_up     = up_q;
    assign bus.step_down   = down_q;
    assign bus.jump        = jump_q;
    assign bus.illegal     = ill_q;
    assign bus.dir         = dir_q;
    assign bus.turn_count  = turn_q;

endmodule

// File: tb/tb_seg_readback.sv
// ---------------------------------------------------------------------------
// tb_seg_readback
//   Directed bench for seg_readback (STABLE_CYCLES=4, TURN_W=8). A table of
//   pattern pairs, hold times and expected pulse counts / resulting state is
//   applied in order; reset, saturation and post-reset behaviour are covered
//   by hand-written sequences. Inputs change just after a falling edge and
//   outputs are sampled on falling edges, so a change is seen as a pulse on
//   the 6th falling edge after it is driven.
// ---------------------------------------------------------------------------
module tb_seg_readback;

    localparam int STABLE = 4;
    localparam int TW     = 8;

    logic clk;
    logic rst;

    seg_readback_if #(.TURN_W(TW)) bus ();

    seg_readback #(
        .STABLE_CYCLES(STABLE),
        .TURN_W       (TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ten;
        logic [7:0] one;
        int         hold;
        int         n_up;
        int         n_down;
        int         n_jump;
        int         n_ill;
        int         first;   // falling edge (1-based) of the first pulse, 0 = none
        int         val;
        int         dir;
        int         turn;
    } vec_t;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] ten, input logic [7:0] one,
                                input int hold, input int n_up, input int n_down,
                                input int n_jump, input int n_ill, input int first,
                                input int val, input int dir, input int turn);
        vec_t v;
        v.ten = ten;   v.one = one;       v.hold = hold;
        v.n_up = n_up; v.n_down = n_down; v.n_jump = n_jump; v.n_ill = n_ill;
        v.first = first; v.val = val; v.dir = dir; v.turn = turn;
        return v;
    endfunction

    function automatic int pulses();
        return int'(bus.step_up) + int'(bus.step_down) + int'(bus.jump) + int'(bus.illegal);
    endfunction

    vec_t vecs[19];

    // Drive one pattern pair, watch it for 'hold' falling edges and compare
    // pulse counts, first-pulse position and the resulting state.
    task automatic apply(input int idx, input vec_t v);
        int c_up, c_dn, c_jmp, c_ill, first, multi;
        c_up = 0; c_dn = 0; c_jmp = 0; c_ill = 0; first = 0; multi = 0;
        bus.seg_ten = v.ten;
        bus.seg_one = v.one;
        for (int k = 1; k <= v.hold; k++) begin
            @(negedge clk);
            c_up  += int'(bus.step_up);
            c_dn  += int'(bus.step_down);
            c_jmp += int'(bus.jump);
            c_ill += int'(bus.illegal);
            if (pulses() > 1) multi = 1;
            if (pulses() != 0 && first == 0) first = k;
        end
        check($sformatf("v%0d.step_up",   idx), c_up,  v.n_up);
        check($sformatf("v%0d.step_down", idx), c_dn,  v.n_down);
        check($sformatf("v%0d.jump",      idx), c_jmp, v.n_jump);
        check($sformatf("v%0d.illegal",   idx), c_ill, v.n_ill);
        check($sformatf("v%0d.first",     idx), first, v.first);
        check($sformatf("v%0d.exclusive", idx), multi, 0);
        check($sformatf("v%0d.value",     idx), int'(bus.value), v.val);
        check($sformatf("v%0d.valid",     idx), int'(bus.value_valid), 1);
        check($sformatf("v%0d.dir",       idx), int'(bus.dir), v.dir);
        check($sformatf("v%0d.turn",      idx), int'(bus.turn_count), v.turn);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".value"},     int'(bus.value),       0);
        check({tag, ".valid"},     int'(bus.value_valid), 0);
        check({tag, ".step_up"},   int'(bus.step_up),     0);
        check({tag, ".step_down"}, int'(bus.step_down),   0);
        check({tag, ".jump"},      int'(bus.jump),        0);
        check({tag, ".illegal"},   int'(bus.illegal),     0);
        check({tag, ".dir"},       int'(bus.dir),         0);
        check({tag, ".turn"},      int'(bus.turn_count),  0);
    endtask

    // After a reset release with pattern (ten,one) already driven, the first
    // accept must load the value with no step/jump pulse.
    task automatic first_accept(input string tag, input int exp_val);
        int first_valid, n_p;
        first_valid = 0; n_p = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_p += pulses();
            if (bus.value_valid && first_valid == 0) first_valid = k;
        end
        check({tag, ".valid_edge"}, first_valid, STABLE + 2);
        check({tag, ".pulses"},     n_p, 0);
        check({tag, ".value"},      int'(bus.value), exp_val);
        check({tag, ".dir"},        int'(bus.dir), 0);
    endtask

    initial begin
        //             ten    one   hold up dn jp il 1st val dir turn
        vecs[0]  = mk(8'h03, 8'h25, 8, 1, 0, 0, 0, 6,  2, 0, 0); // 1 -> 2
        vecs[1]  = mk(8'h03, 8'h0D, 2, 0, 0, 0, 0, 0,  2, 0, 0); // 2-cycle glitch to 3
        vecs[2]  = mk(8'h03, 8'h25, 8, 0, 0, 0, 0, 0,  2, 0, 0); // restored, same value
        vecs[3]  = mk(8'h03, 8'hFF, 8, 0, 0, 0, 1, 6,  2, 0, 0); // blank ones: illegal
        vecs[4]  = mk(8'h09, 8'h09, 8, 0, 0, 1, 0, 6, 99, 0, 0); // 2 -> 99
        vecs[5]  = mk(8'h09, 8'h1F, 8, 0, 0, 1, 0, 6, 97, 0, 0); // 99 -> 97
        vecs[6]  = mk(8'h09, 8'h01, 8, 1, 0, 0, 0, 6, 98, 0, 0);
        vecs[7]  = mk(8'h09, 8'h09, 8, 1, 0, 0, 0, 6, 99, 0, 0);
        vecs[8]  = mk(8'h09, 8'h01, 8, 0, 1, 0, 0, 6, 98, 1, 1); // first reversal
        vecs[9]  = mk(8'h09, 8'h1F, 8, 0, 1, 0, 0, 6, 97, 1, 1);
        vecs[10] = mk(8'h09, 8'h01, 8, 1, 0, 0, 0, 6, 98, 0, 2);
        vecs[11] = mk(8'h09, 8'h09, 8, 1, 0, 0, 0, 6, 99, 0, 2);
        vecs[12] = mk(8'h03, 8'h03, 8, 0, 0, 1, 0, 6,  0, 0, 2); // 99 -> 0 wrap is a jump
        vecs[13] = mk(8'hFF, 8'h03, 8, 0, 0, 0, 0, 0,  0, 0, 2); // blank tens = 0, same value
        vecs[14] = mk(8'hFF, 8'h9F, 8, 1, 0, 0, 0, 6,  1, 0, 2);
        vecs[15] = mk(8'hFF, 8'h03, 8, 0, 1, 0, 0, 6,  0, 1, 3);
        vecs[16] = mk(8'h09, 8'h09, 8, 0, 0, 1, 0, 6, 99, 1, 3); // 0 -> 99 wrap is a jump
        vecs[17] = mk(8'h09, 8'h08, 8, 0, 0, 0, 1, 6, 99, 1, 3); // 9 with dp lit
        vecs[18] = mk(8'h99, 8'h49, 8, 0, 0, 1, 0, 6, 45, 1, 3); // 99 -> 45

        // Reset state
        rst = 1'b0;
        bus.seg_ten = 8'hFF;
        bus.seg_one = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // Release reset with value 1 on the bus; first accept loads it quietly
        bus.seg_ten = 8'h03;
        bus.seg_one = 8'h9F;
        rst = 1'b1;
        first_accept("first", 1);

        for (int i = 0; i < 19; i++)
            apply(i, vecs[i]);

        // 300 alternating steps 45 <-> 46: every step reverses direction
        begin
            int n_up, n_dn;
            n_up = 0; n_dn = 0;
            for (int s = 1; s <= 300; s++) begin
                bus.seg_ten = 8'h99;
                bus.seg_one = (s % 2 == 1) ? 8'h41 : 8'h49;
                repeat (7) begin
                    @(negedge clk);
                    n_up += int'(bus.step_up);
                    n_dn += int'(bus.step_down);
                end
            end
            check("sat.step_up",   n_up, 150);
            check("sat.step_down", n_dn, 150);
            check("sat.turn",      int'(bus.turn_count), 255);
            check("sat.value",     int'(bus.value), 45);
            check("sat.dir",       int'(bus.dir), 1);
        end

        // One-cycle reset mid-run
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b1;
        first_accept("postreset", 45);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
